// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch unit and the control decoder: FSM states,
// instruction width, the HALT encoding and the instruction field layout.
package fetch_pkg;

  localparam int INST_W = 9;
  localparam logic [INST_W-1:0] HALT_INST = 9'h1FF;

  // Instruction fields: opcode in the top bits, LUT key in the bottom bits.
  localparam int OPC_MSB = 8;
  localparam int OPC_LSB = 5;
  localparam int KEY_MSB = 4;
  localparam int KEY_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_EXEC,
    ST_HALTED
  } fetch_state_t;

  function automatic logic [OPC_MSB-OPC_LSB:0] inst_opcode(input logic [INST_W-1:0] inst);
    return inst[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [KEY_MSB-KEY_LSB:0] inst_key(input logic [INST_W-1:0] inst);
    return inst[KEY_MSB:KEY_LSB];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-ROM and decoder-facing bus of the fetch unit.
// The master side is the fetch unit; the slave side is the ROM plus decoder.
interface fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int PC_W = 10
) ();

  logic              rom_rd;
  logic [PC_W-1:0]   rom_addr;
  logic [INST_W-1:0] rom_data;
  logic [INST_W-1:0] inst;
  logic              inst_valid;
  logic              branch_en;
  logic              fetch_acc_en;
  logic [7:0]        acc_value;

  modport master (
    output rom_rd, rom_addr, inst, inst_valid, acc_value,
    input  rom_data, branch_en, fetch_acc_en
  );

  modport slave (
    input  rom_rd, rom_addr, inst, inst_valid, acc_value,
    output rom_data, branch_en, fetch_acc_en
  );

endinterface

// File: rtl/key_lut.sv
// 2^KEY_W-entry register file: one synchronous write port, one combinational
// read port (read-before-write on a same-index collision), cleared on reset.
module key_lut #(
  parameter int KEY_W  = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [KEY_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [KEY_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**KEY_W];

  // NOTE: this table must read zero straight after reset, so it is built from
  // flops that all clear together; a RAM macro could not be wiped in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**KEY_W; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_unit.sv
// Instruction sequencer: fetches from a synchronous ROM, presents each
// instruction to the decoder and follows its branch decision until HALT.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int KEY_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  start_addr,
  input  logic             stall,
  input  logic             lut_we,
  input  logic             lut_sel,
  input  logic [KEY_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]  lut_wdata,
  output logic [PC_W-1:0]  pc,
  output logic             done,
  fetch_unit_if.master     bus
);

  fetch_state_t      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [KEY_W-1:0]  key;
  logic [PC_W-1:0]   branch_target;
  logic [7:0]        acc_rd;
  logic              fetch_acc_unused;

  assign key = inst_q[KEY_LSB +: KEY_W];

  // The accumulator request is the decoder's business; sequencing ignores it.
  assign fetch_acc_unused = bus.fetch_acc_en;

  key_lut #(.KEY_W(KEY_W), .DATA_W(PC_W)) u_branch_lut (
    .clk     (clk),
    .reset   (reset),
    .we_i    (lut_we && !lut_sel),
    .waddr_i (lut_waddr),
    .wdata_i (lut_wdata),
    .raddr_i (key),
    .rdata_o (branch_target)
  );

  key_lut #(.KEY_W(KEY_W), .DATA_W(8)) u_acc_lut (
    .clk     (clk),
    .reset   (reset),
    .we_i    (lut_we && lut_sel),
    .waddr_i (lut_waddr),
    .wdata_i (lut_wdata[7:0]),
    .raddr_i (key),
    .rdata_o (acc_rd)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, whatever order the simulator runs the processes in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    // NOTE: hold values are assigned first so no path through the case leaves
    // a next-state signal unassigned, which would otherwise infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    unique case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          pc_d    = start_addr;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        inst_d  = bus.rom_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (!stall) begin
          if (inst_q == HALT_INST) begin
            state_d = ST_HALTED;
          end else begin
            pc_d    = bus.branch_en ? branch_target : pc_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.rom_rd     = (state_q == ST_FETCH);
  assign bus.rom_addr   = pc_q;
  assign bus.inst       = inst_q;
  assign bus.inst_valid = (state_q == ST_EXEC);
  assign bus.acc_value  = acc_rd;
  assign pc             = pc_q;
  assign done           = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a program-level model compared every cycle,
// plus literal expectations for the documented scenarios.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int PC_W  = 10;
  localparam int KEY_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [PC_W-1:0]  start_addr;
  logic             stall;
  logic             lut_we;
  logic             lut_sel;
  logic [KEY_W-1:0] lut_waddr;
  logic [PC_W-1:0]  lut_wdata;
  logic [PC_W-1:0]  pc;
  logic             done;

  fetch_unit_if #(.PC_W(PC_W)) bus ();

  fetch_unit #(.PC_W(PC_W), .KEY_W(KEY_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .stall      (stall),
    .lut_we     (lut_we),
    .lut_sel    (lut_sel),
    .lut_waddr  (lut_waddr),
    .lut_wdata  (lut_wdata),
    .pc         (pc),
    .done       (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] rom [1024];

  // Synchronous instruction ROM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.rom_rd) bus.rom_data <= rom[bus.rom_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Program-level model: whether a program is running, which of its three
  // phases the current instruction is in, and the architectural pc/inst/LUTs.
  logic       m_init = 1'b0;
  logic       m_run  = 1'b0;
  logic       m_halt = 1'b0;
  int         m_t    = 0;
  logic [9:0] m_pc   = '0;
  logic [8:0] m_inst = '0;
  logic [9:0] blut_m [32];
  logic [7:0] alut_m [32];

  always @(negedge clk) begin : model_cmp
    if (m_init) begin
      check("rom_rd",     bus.rom_rd,     m_run && (m_t == 0));
      check("rom_addr",   bus.rom_addr,   m_pc);
      check("inst",       bus.inst,       m_inst);
      check("inst_valid", bus.inst_valid, m_run && (m_t == 2));
      check("done",       done,           m_halt);
      check("pc",         pc,             m_pc);
      check("acc_value",  bus.acc_value,  alut_m[m_inst[4:0]]);
    end
    // Advance the model to what the next rising edge must produce.
    if (reset) begin
      m_init = 1'b1;
      m_run  = 1'b0;
      m_halt = 1'b0;
      m_t    = 0;
      m_pc   = '0;
      m_inst = '0;
      for (int i = 0; i < 32; i++) begin
        blut_m[i] = '0;
        alut_m[i] = '0;
      end
    end else if (m_init) begin
      if (!m_run) begin
        if (start) begin
          m_run  = 1'b1;
          m_halt = 1'b0;
          m_pc   = start_addr;
          m_t    = 0;
        end
      end else if (m_t == 0) begin
        m_t = 1;
      end else if (m_t == 1) begin
        m_inst = rom[m_pc];
        m_t    = 2;
      end else if (!stall) begin
        if (m_inst == 9'h1FF) begin
          m_run  = 1'b0;
          m_halt = 1'b1;
        end else begin
          m_pc = bus.branch_en ? blut_m[m_inst[4:0]] : m_pc + 10'd1;
          m_t  = 0;
        end
      end
      if (lut_we) begin
        if (lut_sel) alut_m[lut_waddr] = lut_wdata[7:0];
        else         blut_m[lut_waddr] = lut_wdata;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [9:0] addr);
    start      = 1'b1;
    start_addr = addr;
    tick();
    start      = 1'b0;
  endtask

  task automatic lut_write(input logic sel, input logic [4:0] idx, input logic [9:0] data);
    lut_we    = 1'b1;
    lut_sel   = sel;
    lut_waddr = idx;
    lut_wdata = data;
    tick();
    lut_we    = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check(name, done, 1'b1);
  endtask

  logic [8:0] exp_sl [3];

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
    rom[10'h010] = 9'h000;
    rom[10'h011] = 9'h011;
    rom[10'h012] = 9'h1FF;
    rom[10'h020] = 9'h165;
    rom[10'h021] = 9'h1FF;
    rom[10'h200] = 9'h1FF;
    rom[10'h3FF] = 9'h000;
    rom[10'h000] = 9'h1FF;
    rom[10'h030] = 9'h165;
    rom[10'h031] = 9'h1FF;
    rom[10'h040] = 9'h165;
    rom[10'h300] = 9'h1FF;
    exp_sl[0] = 9'h000;
    exp_sl[1] = 9'h011;
    exp_sl[2] = 9'h1FF;

    reset            = 1'b1;
    start            = 1'b0;
    start_addr       = '0;
    stall            = 1'b0;
    lut_we           = 1'b0;
    lut_sel          = 1'b0;
    lut_waddr        = '0;
    lut_wdata        = '0;
    bus.branch_en    = 1'b0;
    bus.fetch_acc_en = 1'b0;
    repeat (3) tick();
    check("reset rom_rd",     bus.rom_rd,     1'b0);
    check("reset rom_addr",   bus.rom_addr,   10'h000);
    check("reset inst",       bus.inst,       9'h000);
    check("reset inst_valid", bus.inst_valid, 1'b0);
    check("reset acc_value",  bus.acc_value,  8'h00);
    check("reset pc",         pc,             10'h000);
    check("reset done",       done,           1'b0);
    reset = 1'b0;
    tick();

    // Straight line: inst_valid on cycles 3, 6 and 9 after the start edge.
    do_start(10'h010);
    for (int k = 1; k <= 9; k++) begin
      check("sl inst_valid", bus.inst_valid, (k % 3) == 0);
      if ((k % 3) == 0) check("sl inst", bus.inst, exp_sl[k/3 - 1]);
      tick();
    end
    check("sl done", done, 1'b1);
    check("sl pc", pc, 10'h012);

    // Taken branch through branch_lut[5].
    lut_write(1'b0, 5'd5, 10'h200);
    bus.branch_en = 1'b1;
    do_start(10'h020);
    repeat (3) tick();
    check("taken rom_rd", bus.rom_rd, 1'b1);
    check("taken rom_addr", bus.rom_addr, 10'h200);
    wait_done("taken done");
    bus.branch_en = 1'b0;

    // Not taken.
    do_start(10'h020);
    repeat (3) tick();
    check("fall rom_addr", bus.rom_addr, 10'h021);
    wait_done("fall done");

    // pc wraps from the top of the address space.
    do_start(10'h3FF);
    repeat (3) tick();
    check("wrap rom_addr", bus.rom_addr, 10'h000);
    wait_done("wrap done");
    check("wrap pc", pc, 10'h000);

    // Stall in EXEC with branch_en pulses that must be ignored.
    do_start(10'h030);
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      stall         = 1'b1;
      bus.branch_en = (i % 2) == 0;
      tick();
      check("stall inst_valid", bus.inst_valid, 1'b1);
      check("stall inst", bus.inst, 9'h165);
      check("stall pc", pc, 10'h030);
    end
    stall         = 1'b0;
    bus.branch_en = 1'b0;
    tick();
    check("stall resume rom_rd", bus.rom_rd, 1'b1);
    check("stall resume rom_addr", bus.rom_addr, 10'h031);
    wait_done("stall done");

    // Same-cycle LUT write and taken branch on key 5 uses the old target.
    lut_write(1'b1, 5'd5, 10'h3AB);
    bus.branch_en    = 1'b1;
    bus.fetch_acc_en = 1'b1;
    do_start(10'h040);
    repeat (2) tick();
    check("acc_value key5", bus.acc_value, 8'hAB);
    lut_we    = 1'b1;
    lut_sel   = 1'b0;
    lut_waddr = 5'd5;
    lut_wdata = 10'h300;
    tick();
    lut_we = 1'b0;
    check("collide rom_addr", bus.rom_addr, 10'h200);
    wait_done("collide done");
    do_start(10'h040);
    repeat (3) tick();
    check("after write rom_addr", bus.rom_addr, 10'h300);
    wait_done("after write done");
    bus.branch_en    = 1'b0;
    bus.fetch_acc_en = 1'b0;

    // Reset while the instruction is in LOAD.
    do_start(10'h010);
    tick();
    reset = 1'b1;
    tick();
    check("rst pc", pc, 10'h000);
    check("rst inst_valid", bus.inst_valid, 1'b0);
    check("rst done", done, 1'b0);
    reset = 1'b0;
    repeat (2) tick();
    check("idle rom_rd", bus.rom_rd, 1'b0);
    check("idle inst_valid", bus.inst_valid, 1'b0);

    // start during FETCH is ignored; start from HALTED relaunches.
    do_start(10'h010);
    start      = 1'b1;
    start_addr = 10'h3FF;
    tick();
    start = 1'b0;
    wait_done("ignore start done");
    check("ignore start pc", pc, 10'h012);
    do_start(10'h020);
    repeat (3) tick();
    check("relaunch rom_addr", bus.rom_addr, 10'h021);
    wait_done("relaunch done");
    check("relaunch pc", pc, 10'h021);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction sequencer that produces 9-bit instructions for the control decoder and consumes its `branch_en` and `fetch_acc_en` responses. Owns the program counter, the 32-entry branch-target LUT and the 32-entry accumulator-constant LUT, both indexed by `inst[4:0]`. Drives a synchronous instruction ROM and stops on the HALT encoding.

## Interface
- `PC_W`, 10, program-counter / ROM address width
- `KEY_W`, 5, LUT index width (LUT depth 2^KEY_W = 32)
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  launch program at `start_addr`; honoured in IDLE or HALTED only
- `start_addr`  in  PC_W  first instruction address
- `stall`  in  1  hold current instruction in EXEC
- `rom_rd`  out  1  instruction ROM read strobe
- `rom_addr`  out  PC_W  ROM address (= pc)
- `rom_data`  in  9  ROM output, valid the cycle after `rom_rd`
- `inst`  out  9  instruction to decoder
- `inst_valid`  out  1  `inst` is live this cycle
- `branch_en`  in  1  decoder's branch decision, sampled only when `inst_valid`
- `fetch_acc_en`  in  1  decoder's accumulator-constant request, sampled only when `inst_valid`
- `acc_value`  out  8  `acc_lut[inst[4:0]]`, combinational
- `lut_we`  in  1  LUT write strobe
- `lut_sel`  in  1  0 = branch LUT, 1 = accumulator LUT
- `lut_waddr`  in  KEY_W  LUT write index
- `lut_wdata`  in  PC_W  write data; acc LUT keeps bits [7:0]
- `pc`  out  PC_W  current program counter
- `done`  out  1  high while HALTED

## Operation
- States: IDLE, FETCH, LOAD, EXEC, HALTED.
- IDLE: outputs quiet. On `start`: pc <= `start_addr`, go to FETCH.
- FETCH: `rom_rd`=1 with `rom_addr`=pc, go to LOAD.
- LOAD: inst_q <= `rom_data`, go to EXEC.
- EXEC: `inst_valid`=1.
  - `stall`=1: hold state, pc and inst_q; `branch_en` ignored.
  - inst_q == HALT (9'h1FF): go to HALTED; pc unchanged.
  - `branch_en`=1: pc <= branch_lut[inst_q[4:0]], go to FETCH.
  - Otherwise: pc <= pc+1 modulo 2^PC_W, go to FETCH.
- `fetch_acc_en` does not affect sequencing; `acc_value` is valid whenever `inst_valid`=1.
- HALTED: `done`=1. `start` relaunches exactly as from IDLE.
- `start` in FETCH, LOAD or EXEC is ignored.
- LUT writes are accepted in every state.
  - Write and branch read to the same index in the same cycle: branch uses the old entry (read-before-write).
  - Same for `acc_value`.
- Reset to IDLE clears pc, inst_q and both LUTs to 0. This applies mid-instruction as well, with no completion of the in-flight instruction.

## Timing
- Reset values: `rom_rd`=0, `rom_addr`=0, `inst`=0, `inst_valid`=0, `acc_value`=0, `pc`=0, `done`=0.
- Throughput is 3 cycles per instruction without stall.
- `start` sampled at edge N:
  - FETCH in N+1
  - `rom_data` sampled in N+2
  - `inst_valid` in N+3
- Branch decision sampled at the end of EXEC; the target address appears on `rom_addr` in the next cycle.
- `inst`, `inst_valid`, `done`, `rom_rd` and `pc` are registered or state-decoded only.
- `acc_value` is the only LUT-read combinational output.

## Structure
- Shared package `fetch_pkg` holds:
  - state enum `fetch_state_t`
  - `HALT_INST` = 9'h1FF
  - `INST_W` = 9
  - opcode field positions, shared with the decoder
- Sub-module `key_lut`: parameterised 2^KEY_W × data-width register file with one synchronous write port, one combinational read port and synchronous clear on reset. Instantiated twice, widths PC_W and 8.

## Test plan
- Straight line: ROM[0x010..0x012] = 9'h000, 9'h011, 9'h1FF; `start_addr`=0x010.
  - `inst_valid` pulses at cycles 3, 6, 9 after start with those instructions.
  - `done`=1 with `pc`=0x012.
- Taken branch: branch_lut[5] = 0x200; ROM[0x020] = 9'h165; decoder `branch_en`=1.
  - Next `rom_addr` is 0x200.
  - Same with `branch_en`=0 → next `rom_addr` is 0x021.
- Wrap: `start_addr`=0x3FF, non-branch instruction → next fetch at `rom_addr` 0x000.
- Stall: hold `stall`=1 for 4 cycles in EXEC.
  - `inst` and `pc` are constant and `inst_valid` stays 1.
  - `branch_en` pulses during the stall are ignored.
  - Fetch resumes one cycle after `stall` falls.
- LUT collision: `lut_we`=1, `lut_sel`=0, `lut_waddr`=5, `lut_wdata`=0x300, written in the same EXEC cycle as a taken branch on key 5.
  - This branch goes to 0x200.
  - A later branch on key 5 goes to 0x300.
- Reset mid-LOAD: pc, `inst_valid` and `done` read 0 the next cycle and the state is IDLE.
  - `start` during FETCH is ignored; `start` in HALTED relaunches.
